multi_channel_message_queue: RTL
================================

# multi_channel_message_queue

Parametrised successor to the NIC's single-queue message buffer. Packets arriving from the NoC are reassembled into bus messages and held in N independent per-channel circular queues (virtual channels / traffic classes). An output arbiter presents one message at a time to the WISHBONE master interface, which drives address, data, select, direction and burst length, and reports beat advance, retry and completion back to the queue.

## Interface
- N_CHANNELS, 2, number of independent message queues
- N_BITS_CHANNEL, clog2(N_CHANNELS), channel index width (minimum 1)
- QUEUE_DEPTH, 4, message slots per channel (power of two)
- N_BITS_POINTER, clog2(QUEUE_DEPTH), slot pointer width
- FLIT_WIDTH, 16, flit width; also bus address and data width
- MAX_PACKET_LENGHT, 5, flits per packet (header + address + up to MAX_PACKET_LENGHT-2 data)
- GRANULARITY, 8, bus select granularity
- N_BITS_BURST_LENGHT, clog2(MAX_PACKET_LENGHT-2)+1, burst field width

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_link_i  in  MAX_PACKET_LENGHT*FLIT_WIDTH  packet; flit k at bits [k*FLIT_WIDTH +: FLIT_WIDTH]
- in_sel_i  in  MAX_PACKET_LENGHT  valid-flit mask, contiguous from bit 0
- in_channel_i  in  N_BITS_CHANNEL  target channel
- r_pkt_to_msg_i  in  1  packet store request
- g_pkt_to_msg_o  out  1  one-cycle store grant
- full_o  out  N_CHANNELS  per-channel full flags
- message_transmitted_i  in  1  current message completed on bus
- next_data_i  in  1  advance to next data beat
- retry_i  in  1  restart current message from beat 0
- r_bus_arbitration_o  out  1  message valid, request bus
- address_o  out  FLIT_WIDTH  flit 1 of current message
- data_o  out  FLIT_WIDTH  data flit 2+beat of current message
- sel_o  out  FLIT_WIDTH/GRANULARITY  all ones while r_bus_arbitration_o, else 0
- transaction_type_o  out  1  header bit 0 (1 = write)
- burst_lenght_o  out  N_BITS_BURST_LENGHT  header bits [N_BITS_BURST_LENGHT:1]
- channel_o  out  N_BITS_CHANNEL  channel of current message

## Operation
- Store: on edge where r_pkt_to_msg_i && !g_pkt_to_msg_o && !full[in_channel_i], packet and mask written to that channel's tail slot, tail and count increment; g_pkt_to_msg_o high the next cycle only. Request while full: held off, no grant, no write. Requester drops r in the grant cycle; r high during grant is never a second accept.
- Full/empty per channel from count (0..QUEUE_DEPTH); pointers wrap modulo QUEUE_DEPTH. Full evaluated before same-edge pop (no bypass).
- Output FSM: IDLE -> ACTIVE when any channel non-empty; selected channel latched in channel_o, beat = 0. ACTIVE: next_data_i increments beat (saturates at MAX_PACKET_LENGHT-3); retry_i sets beat = 0; message_transmitted_i pops head, goes IDLE. Priority: message_transmitted_i > retry_i > next_data_i.
- Arbitration: round-robin, search starts at channel after last served.
- Queue does not validate burst field against data flit count; data_o for beats beyond valid flits is the stored value, undefined.
- Reset: all counts/pointers 0, FSM IDLE, round-robin pointer 0, every output 0.

## Timing
- Accept edge E: g_pkt_to_msg_o high cycle E..E+1; if output IDLE and all other channels empty, r_bus_arbitration_o high from E+1 (one-cycle latency).
- message_transmitted_i sampled at edge T: r_bus_arbitration_o low from T for exactly one cycle; next message (if any) presented from T+1.
- Beat change visible on data_o the cycle after the sampling edge.
- Push and pop same channel same edge: both take effect, count unchanged.
- rst asserted mid-message: in-flight and queued messages discarded; outputs 0 next cycle.

## Configuration
- MSG_QUEUE_STRICT_PRIORITY_EN defined: arbiter is fixed priority, lowest channel index wins; round-robin pointer removed.
- Undefined: round-robin as above.

## Test plan
- Small write: ch0, in_link flits {0x0003,0x1000,0xBBB1}, in_sel 5'b00111 -> grant pulse, next cycle r_bus_arbitration_o=1, address_o=0x1000, data_o=0xBBB1, transaction_type_o=1, burst_lenght_o=1, sel_o all ones.
- Burst with retry: write flits {0x0007,0x2000,0xA1,0xA2,0xA3}; two next_data_i -> data_o 0xA3; retry_i -> 0xA1; message_transmitted_i -> r_bus_arbitration_o low one cycle, then 0.
- Saturation: 5 requests to ch1 without completions -> 4 grants, full_o=2'b10, fifth held until one message_transmitted_i, then granted.
- Fairness: 2 messages each in ch0 and ch1 -> service order ch0,ch1,ch0,ch1 (with macro: ch0,ch0,ch1,ch1).
- Simultaneous: message_transmitted_i with retry_i and next_data_i -> pop only; push on full channel same edge as its pop -> no grant that edge.
- Reset during ACTIVE burst -> all outputs 0, full_o=0, later push behaves as fresh.

Source files
------------

// File: rtl/multi_channel_message_queue.sv
// Per-channel circular message queues feeding one arbitrated WISHBONE-facing output stage.
// Build option: define MSG_QUEUE_STRICT_PRIORITY_EN for fixed lowest-index-first arbitration.
module multi_channel_message_queue #(
    parameter int N_CHANNELS          = 2,
    parameter int N_BITS_CHANNEL      = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    parameter int QUEUE_DEPTH         = 4,
    parameter int N_BITS_POINTER      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1,
    parameter int FLIT_WIDTH          = 16,
    parameter int MAX_PACKET_LENGHT   = 5,
    parameter int GRANULARITY         = 8,
    parameter int N_BITS_BURST_LENGHT = $clog2(MAX_PACKET_LENGHT - 2) + 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] in_link_i,
    input  logic [MAX_PACKET_LENGHT-1:0]            in_sel_i,
    input  logic [N_BITS_CHANNEL-1:0]               in_channel_i,
    input  logic                                    r_pkt_to_msg_i,
    output logic                                    g_pkt_to_msg_o,
    output logic [N_CHANNELS-1:0]                   full_o,
    input  logic                                    message_transmitted_i,
    input  logic                                    next_data_i,
    input  logic                                    retry_i,
    output logic                                    r_bus_arbitration_o,
    output logic [FLIT_WIDTH-1:0]                   address_o,
    output logic [FLIT_WIDTH-1:0]                   data_o,
    output logic [FLIT_WIDTH/GRANULARITY-1:0]       sel_o,
    output logic                                    transaction_type_o,
    output logic [N_BITS_BURST_LENGHT-1:0]          burst_lenght_o,
    output logic [N_BITS_CHANNEL-1:0]               channel_o
);
    localparam int BODY_W = (MAX_PACKET_LENGHT - 1) * FLIT_WIDTH;
    localparam int HDR_W  = N_BITS_BURST_LENGHT + 1;
    localparam int SEL_W  = FLIT_WIDTH / GRANULARITY;
    localparam int BEAT_W = (MAX_PACKET_LENGHT > 3) ? $clog2(MAX_PACKET_LENGHT - 2) : 1;
    localparam int CNT_W  = N_BITS_POINTER + 1;
    localparam logic [BEAT_W-1:0]         BEAT_MAX = BEAT_W'(MAX_PACKET_LENGHT - 3);
    localparam logic [CNT_W-1:0]          CNT_FULL = CNT_W'(QUEUE_DEPTH);
    localparam logic [N_BITS_POINTER-1:0] PTR_LAST = N_BITS_POINTER'(QUEUE_DEPTH - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

    // Only the header bits the bus needs and the address/data flits are kept.
    logic [HDR_W-1:0]          hdr_mem_r  [N_CHANNELS][QUEUE_DEPTH];
    logic [BODY_W-1:0]         body_mem_r [N_CHANNELS][QUEUE_DEPTH];
    logic [N_BITS_POINTER-1:0] head_r     [N_CHANNELS];
    logic [N_BITS_POINTER-1:0] tail_r     [N_CHANNELS];
    logic [CNT_W-1:0]          count_r    [N_CHANNELS];
    logic [N_CHANNELS-1:0]     full_r;

    state_t                    state_r, state_s;
    logic [BEAT_W-1:0]         beat_r, beat_s;
    logic [N_BITS_CHANNEL-1:0] chan_r, chan_s, pick_s, start_s;
    logic                      found_s, hit_s, accept_s, act_s;
    logic [N_CHANNELS-1:0]     push_s, pop_s;
    logic [HDR_W-1:0]          masked_hdr_s, head_hdr_s;
    logic [BODY_W-1:0]         masked_body_s, head_body_s;

    function automatic logic [N_BITS_POINTER-1:0] ptr_inc(input logic [N_BITS_POINTER-1:0] p);
        ptr_inc = (p == PTR_LAST) ? {N_BITS_POINTER{1'b0}} : p + N_BITS_POINTER'(1);
    endfunction

    function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] c,
                                                    input logic push, input logic pop);
        count_next = c + CNT_W'(push) - CNT_W'(pop);
    endfunction

    assign full_o   = full_r;
    // Full is the registered pre-edge flag, so a pop never makes room on its own edge.
    assign accept_s = r_pkt_to_msg_i && !g_pkt_to_msg_o && !full_r[in_channel_i];
    assign act_s    = (state_s == ST_ACTIVE);

`ifdef MSG_QUEUE_STRICT_PRIORITY_EN
    assign start_s = {N_BITS_CHANNEL{1'b0}};
`else
    logic [N_BITS_CHANNEL-1:0] rr_r;
    assign start_s = rr_r;

    // Round-robin pointer: search starts just after the channel most recently granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_r <= {N_BITS_CHANNEL{1'b0}};
        end else if (state_r == ST_IDLE && found_s) begin
            rr_r <= (int'(pick_s) == N_CHANNELS - 1) ? {N_BITS_CHANNEL{1'b0}}
                                                      : pick_s + N_BITS_CHANNEL'(1);
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // Per-channel push/pop strobes and masked copy of the incoming packet.
    always_comb begin
        push_s        = '0;
        pop_s         = '0;
        masked_body_s = '0;
        masked_hdr_s  = in_sel_i[0] ? in_link_i[HDR_W-1:0] : {HDR_W{1'b0}};
        for (int c = 0; c < N_CHANNELS; c++) begin
            push_s[c] = accept_s && (int'(in_channel_i) == c);
            pop_s[c]  = (state_r == ST_ACTIVE) && message_transmitted_i && (int'(chan_r) == c);
        end
        for (int k = 1; k < MAX_PACKET_LENGHT; k++) begin
            masked_body_s[(k-1)*FLIT_WIDTH +: FLIT_WIDTH] =
                in_sel_i[k] ? in_link_i[k*FLIT_WIDTH +: FLIT_WIDTH] : {FLIT_WIDTH{1'b0}};
        end
    end

    // First non-empty channel found scanning upward from the start channel.
    always_comb begin
        pick_s  = {N_BITS_CHANNEL{1'b0}};
        found_s = 1'b0;
        hit_s   = 1'b0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            hit_s   = !found_s && (count_r[(int'(start_s) + i) % N_CHANNELS] != {CNT_W{1'b0}});
            pick_s  = hit_s ? N_BITS_CHANNEL'((int'(start_s) + i) % N_CHANNELS) : pick_s;
            found_s = found_s | hit_s;
        end
    end

    // Queue bookkeeping: pointers, occupancy, full flags and the store grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            g_pkt_to_msg_o <= 1'b0;
            full_r         <= '0;
            for (int c = 0; c < N_CHANNELS; c++) begin
                head_r[c]  <= {N_BITS_POINTER{1'b0}};
                tail_r[c]  <= {N_BITS_POINTER{1'b0}};
                count_r[c] <= {CNT_W{1'b0}};
            end
        end else begin
            g_pkt_to_msg_o <= accept_s;
            for (int c = 0; c < N_CHANNELS; c++) begin
                head_r[c]  <= pop_s[c]  ? ptr_inc(head_r[c]) : head_r[c];
                tail_r[c]  <= push_s[c] ? ptr_inc(tail_r[c]) : tail_r[c];
                count_r[c] <= count_next(count_r[c], push_s[c], pop_s[c]);
                full_r[c]  <= (count_next(count_r[c], push_s[c], pop_s[c]) == CNT_FULL);
            end
        end
    end

    // Message storage; contents are qualified by the counters so need no reset.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            hdr_mem_r[in_channel_i][tail_r[in_channel_i]]  <= masked_hdr_s;
            body_mem_r[in_channel_i][tail_r[in_channel_i]] <= masked_body_s;
        end else begin
            hdr_mem_r[in_channel_i][tail_r[in_channel_i]]  <= hdr_mem_r[in_channel_i][tail_r[in_channel_i]];
            body_mem_r[in_channel_i][tail_r[in_channel_i]] <= body_mem_r[in_channel_i][tail_r[in_channel_i]];
        end
    end

    // Output FSM next state; completion outranks retry, retry outranks beat advance.
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        chan_s  = chan_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    state_s = ST_ACTIVE;
                    chan_s  = pick_s;
                    beat_s  = {BEAT_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (message_transmitted_i) begin
                    state_s = ST_IDLE;
                    beat_s  = {BEAT_W{1'b0}};
                end else if (retry_i) begin
                    beat_s = {BEAT_W{1'b0}};
                end else if (next_data_i && beat_r != BEAT_MAX) begin
                    beat_s = beat_r + BEAT_W'(1);
                end else begin
                    beat_s = beat_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
                beat_s  = {BEAT_W{1'b0}};
            end
        endcase
    end

    assign head_hdr_s  = hdr_mem_r[chan_s][head_r[chan_s]];
    assign head_body_s = body_mem_r[chan_s][head_r[chan_s]];

    // FSM state plus registered bus outputs, forced to zero while no message is presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= ST_IDLE;
            beat_r              <= {BEAT_W{1'b0}};
            chan_r              <= {N_BITS_CHANNEL{1'b0}};
            r_bus_arbitration_o <= 1'b0;
            address_o           <= {FLIT_WIDTH{1'b0}};
            data_o              <= {FLIT_WIDTH{1'b0}};
            sel_o               <= {SEL_W{1'b0}};
            transaction_type_o  <= 1'b0;
            burst_lenght_o      <= {N_BITS_BURST_LENGHT{1'b0}};
            channel_o           <= {N_BITS_CHANNEL{1'b0}};
        end else begin
            state_r             <= state_s;
            beat_r              <= beat_s;
            chan_r              <= chan_s;
            r_bus_arbitration_o <= act_s;
            address_o           <= act_s ? head_body_s[FLIT_WIDTH-1:0] : {FLIT_WIDTH{1'b0}};
            data_o              <= act_s ? head_body_s[(int'(beat_s) + 1)*FLIT_WIDTH +: FLIT_WIDTH]
                                         : {FLIT_WIDTH{1'b0}};
            sel_o               <= act_s ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
            transaction_type_o  <= act_s ? head_hdr_s[0] : 1'b0;
            burst_lenght_o      <= act_s ? head_hdr_s[HDR_W-1:1] : {N_BITS_BURST_LENGHT{1'b0}};
            channel_o           <= act_s ? chan_s : {N_BITS_CHANNEL{1'b0}};
        end
    end

endmodule
